// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DefWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMrun,
    StDrun,
    StFix
  } state_e;

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/twos_abs.sv
// Combinational conditional two's-complement negate.
module twos_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer and datapath for signed MULT/DIV: 32-step shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final state.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MULT_control,
  input  logic             DIV_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             multStop,
  output logic             divStop,
  output logic             div_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic               sign_p_q, sign_p_d, sign_r_q, sign_r_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               mult_stop_q, mult_stop_d, div_stop_q, div_stop_d;
  logic               div_zero_q, div_zero_d;
  logic               mult_ctl_q, div_ctl_q;

  logic               mult_start, div_start;
  logic [WIDTH-1:0]   a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_add, mul_sum, div_part, div_diff;

  assign mult_start = MULT_control & ~mult_ctl_q;
  assign div_start  = DIV_control & ~div_ctl_q;

  twos_abs #(.WIDTH(WIDTH)) u_a_abs (.value(A), .neg(A[WIDTH-1]), .result(a_mag));
  twos_abs #(.WIDTH(WIDTH)) u_b_abs (.value(B), .neg(B[WIDTH-1]), .result(b_mag));
  twos_abs #(.WIDTH(2*WIDTH)) u_prod_fix (.value(prod_q), .neg(sign_p_q), .result(prod_fix));
  twos_abs #(.WIDTH(WIDTH)) u_quot_fix (
    .value (prod_q[WIDTH-1:0]),
    .neg   (sign_p_q),
    .result(quot_fix)
  );
  twos_abs #(.WIDTH(WIDTH)) u_rem_fix (
    .value (prod_q[2*WIDTH-1:WIDTH]),
    .neg   (sign_r_q),
    .result(rem_fix)
  );

  // Multiply: upper half accumulates, whole register shifts right each step.
  assign mul_add = prod_q[0] ? {1'b0, ma_q} : '0;
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + mul_add;

  // Divide: prod holds {remainder, quotient}; partial remainder is WIDTH+1 bits.
  assign div_part = prod_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, mb_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    sign_p_d    = sign_p_q;
    sign_r_d    = sign_r_q;
    is_div_d    = is_div_q;
    prod_d      = prod_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mult_stop_d = 1'b0;
    div_stop_d  = 1'b0;
    div_zero_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mult_start || (div_start && (B != '0))) begin
          ma_d     = a_mag;
          mb_d     = b_mag;
          sign_p_d = A[WIDTH-1] ^ B[WIDTH-1];
          sign_r_d = A[WIDTH-1];
          cnt_d    = '0;
        end
        if (mult_start) begin
          state_d  = StMrun;
          is_div_d = 1'b0;
          prod_d   = {{WIDTH{1'b0}}, b_mag};
        end else if (div_start) begin
          if (B == '0) begin
            div_stop_d = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d  = StDrun;
            is_div_d = 1'b1;
            prod_d   = {{WIDTH{1'b0}}, a_mag};
          end
        end
      end
      StMrun: begin
        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == LastIter) state_d = StFix;
      end
      StDrun: begin
        if (!div_diff[WIDTH]) prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else                  prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastIter) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        if (is_div_q) begin
          hi_d       = rem_fix;
          lo_d       = quot_fix;
          div_stop_d = 1'b1;
        end else begin
          hi_d        = prod_fix[2*WIDTH-1:WIDTH];
          lo_d        = prod_fix[WIDTH-1:0];
          mult_stop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      sign_p_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      is_div_q    <= 1'b0;
      prod_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mult_stop_q <= 1'b0;
      div_stop_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      mult_ctl_q  <= 1'b0;
      div_ctl_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      sign_p_q    <= sign_p_d;
      sign_r_q    <= sign_r_d;
      is_div_q    <= is_div_d;
      prod_q      <= prod_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mult_stop_q <= mult_stop_d;
      div_stop_q  <= div_stop_d;
      div_zero_q  <= div_zero_d;
      mult_ctl_q  <= MULT_control;
      div_ctl_q   <= DIV_control;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = (state_q != StIdle);
  assign multStop = mult_stop_q;
  assign divStop  = div_stop_q;
  assign div_zero = div_zero_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer and iterative datapath for the signed MULT/DIV instructions. The main control unit drives it through `MULT_control`/`DIV_control` and waits on `multStop`/`divStop`. It reads operands from the A/B registers, runs a 32-step shift-add multiply or restoring divide, and then loads the HI/LO results. It also flags divide-by-zero so the control unit can enter its DIVYBZERO exception sequence.

## Interface
- `WIDTH`, default 32: operand and result width. Iteration count equals `WIDTH`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `MULT_control`  in  1  multiply request. Only its rising edge is acted on.
- `DIV_control`  in  1  divide request. Only its rising edge is acted on.
- `A`  in  WIDTH  multiplicand / dividend, two's complement.
- `B`  in  WIDTH  multiplier / divisor, two's complement.
- `HI`  out  WIDTH  product upper half / remainder.
- `LO`  out  WIDTH  product lower half / quotient.
- `busy`  out  1  an operation is in progress.
- `multStop`  out  1  one-cycle pulse: multiply result is valid.
- `divStop`  out  1  one-cycle pulse: divide finished, or aborted on divide-by-zero.
- `div_zero`  out  1  one-cycle pulse, coincident with `divStop`, when B was 0.

## Operation
- Reset: state IDLE. `HI`, `LO` = 0. `busy`, `multStop`, `divStop`, `div_zero` = 0. Edge-detect registers = 0.
- Start detection:
  - start = control & ~control_q, registered every cycle.
  - Starts are honoured only in IDLE and ignored while busy. They are not queued.
  - If both starts occur in the same cycle, multiply wins and the divide is dropped.
- States and transitions:
  - IDLE → MRUN on a multiply start.
  - IDLE → DRUN on a divide start with B ≠ 0.
  - IDLE → IDLE on a divide start with B = 0: pulse `divStop` and `div_zero`; HI/LO unchanged.
  - MRUN / DRUN → FIX after `WIDTH` iterations.
  - FIX → IDLE: write HI/LO and pulse the matching Stop.
- Operand latch at start:
  - Store |A| and |B| in WIDTH-bit unsigned registers.
  - Store sign_p = A[msb] ^ B[msb] and sign_r = A[msb].
  - |−2^(WIDTH−1)| is 2^(WIDTH−1) as unsigned; no saturation.
- Multiply, one step per cycle:
  - Unsigned shift-add on a 2·WIDTH product register.
  - FIX negates the full 2·WIDTH product if sign_p = 1.
- Divide, one step per cycle:
  - Unsigned restoring division with a WIDTH+1-bit partial remainder.
  - FIX negates the quotient if sign_p = 1 and negates the remainder if sign_r = 1.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - −2^31 / −1 gives LO = 0x80000000, HI = 0. No overflow flag.
- HI/LO change only in FIX or on reset. They hold their value indefinitely otherwise, including across ignored starts.
- Reset mid-operation: abort immediately with no Stop pulse. HI/LO are cleared.

## Timing
- Cycle 0 is the cycle in which the rising edge of a control input is detected. Operands are latched at the end of cycle 0.
- `busy` is high in cycles 1 through WIDTH+1, which is 1–33 at the default width.
- Iterations run in cycles 1..WIDTH. FIX is cycle WIDTH+1.
- `multStop` / `divStop` are high only in cycle WIDTH+2 (cycle 34 at the default width). HI/LO are valid from that cycle on.
- Divide-by-zero: `divStop` and `div_zero` are high in cycle 1. `busy` stays 0.
- A new request is accepted at the earliest in the cycle in which Stop is high.
  - This needs a fresh rising edge.
  - A control input held high across completion does not retrigger.
- Operands A/B may change after cycle 0 without effect.

## Structure
- Shared package `muldiv_pkg`:
  - state encoding (IDLE, MRUN, DRUN, FIX),
  - the `WIDTH` default,
  - the iteration counter width, $clog2(WIDTH)+1.
- One natural sub-module: `twos_abs`, a combinational conditional two's-complement negate. It is reused for operand magnitude and result sign fix-up; instantiate it at WIDTH and 2·WIDTH.
- Everything else (counter, product/remainder registers, FSM) lives in `muldiv_seq`.

## Test plan
- Multiply A=7, B=−3 (0xFFFFFFFD) → HI=0xFFFFFFFF, LO=0xFFFFFFEB. `multStop` high exactly in cycle 34 for one cycle. `busy` high in cycles 1–33.
- Multiply A=B=0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001. Also multiply A=0x80000000, B=0x80000000 → HI=0x40000000, LO=0.
- Divide A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, with `divStop` in cycle 34. Divide A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide A=5, B=0 with prior HI/LO = 0x11/0x22 → `divStop` and `div_zero` high in cycle 1 only, `busy` never high, HI/LO still 0x11/0x22.
- Assert reset in cycle 10 of a multiply → next cycle `busy`=0, HI=LO=0, and no Stop pulse ever. A subsequent multiply 3×4 → LO=12 in cycle 34.
- Rising edges on both controls in the same cycle → multiply only, and `divStop` never asserts. A `DIV_control` edge in cycle 5 is ignored. `MULT_control` held high through completion causes no second operation.
